// File: rtl/replay_ctrl.sv
// rtl/replay_ctrl.sv - replay buffer controller: sequence numbering, ACK/NAK purge, timed replay and retrain escalation
module replay_ctrl #(
    parameter int AW      = 3,
    parameter int SEQ_W   = 12,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tlp_valid,
    output logic             tlp_ready,
    output logic [SEQ_W-1:0] tx_seq,
    output logic             buf_we,
    output logic [AW-1:0]    buf_waddr,
    output logic             buf_re,
    output logic [AW-1:0]    buf_raddr,
    output logic             replay_valid,
    input  logic             tx_ready,
    input  logic             dllp_valid,
    output logic             dllp_ready,
    input  logic             dllp_nak,
    input  logic [SEQ_W-1:0] dllp_seq,
    output logic             dllp_err,
    output logic             replay_active,
    output logic             retrain_req,
    input  logic             retrain_done,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << AW;
    localparam int TW    = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT - 1);
    localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        REPLAY  = 2'd1,
        RETRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_base_q, rd_base_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [AW:0]      remaining_q, remaining_d;
    logic [SEQ_W-1:0] next_seq_q, next_seq_d;
    logic [SEQ_W-1:0] acked_seq_q, acked_seq_d;
    logic [1:0]       replay_num_q, replay_num_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             replay_valid_q, replay_valid_d;
    logic             dllp_err_q, dllp_err_d;
    logic             retrain_req_q, retrain_req_d;

    logic             accept;
    logic             consume;
    logic [SEQ_W-1:0] ack_dist;
    logic             out_of_window;
    logic             purge;
    logic             progress;
    logic [AW:0]      purge_cnt;
    logic [AW:0]      count_after;
    logic [1:0]       replay_num_base;
    logic             start_replay;

    assign full          = (count_q == COUNT_FULL);
    assign empty         = (count_q == '0);
    assign count         = count_q;
    assign tlp_ready     = (state_q == NORMAL) && !full;
    assign dllp_ready    = (state_q == NORMAL);
    assign accept        = tlp_valid && tlp_ready;
    assign consume       = dllp_valid && dllp_ready;
    assign buf_we        = accept;
    assign buf_waddr     = wr_ptr_q;
    assign tx_seq        = next_seq_q;
    assign buf_re        = (state_q == REPLAY) && tx_ready;
    assign buf_raddr     = rd_ptr_q;
    assign replay_valid  = replay_valid_q;
    assign dllp_err      = dllp_err_q;
    assign replay_active = (state_q == REPLAY);
    assign retrain_req   = retrain_req_q;

    // Distance from the last acknowledged sequence number; anything beyond the
    // outstanding count refers to a TLP we never sent and is rejected.
    assign ack_dist        = dllp_seq - acked_seq_q;
    assign out_of_window   = ack_dist > SEQ_W'(count_q);
    assign purge           = consume && !out_of_window;
    assign progress        = purge && (ack_dist != '0);
    assign purge_cnt       = purge ? ack_dist[AW:0] : '0;
    assign count_after     = count_q - purge_cnt + {{AW{1'b0}}, accept};
    assign replay_num_base = progress ? 2'd0 : replay_num_q;
    // A DLLP consumed this cycle masks the timeout, so NAK+timeout replays once.
    assign start_replay    = (state_q == NORMAL) &&
                             ((purge && dllp_nak && (count_after != '0)) ||
                              (!consume && (count_q != '0) && (timer_q == TIMER_MAX)));

    // Next-state logic for pointers, counters, sequence numbers and the FSM.
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_base_d      = rd_base_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        remaining_d    = remaining_q;
        next_seq_d     = next_seq_q;
        acked_seq_d    = acked_seq_q;
        replay_num_d   = replay_num_q;
        timer_d        = timer_q;
        retrain_req_d  = retrain_req_q;
        dllp_err_d     = consume && out_of_window;
        replay_valid_d = buf_re;

        case (state_q)
            NORMAL: begin
                count_d = count_after;
                if (accept) begin
                    wr_ptr_d   = wr_ptr_q + AW'(1);
                    next_seq_d = next_seq_q + SEQ_W'(1);
                end
                if (purge) begin
                    rd_base_d   = rd_base_q + purge_cnt[AW-1:0];
                    acked_seq_d = dllp_seq;
                end
                replay_num_d = replay_num_base;
                // Timer saturates so a DLLP-masked expiry still fires next cycle.
                if (progress || (count_q == '0)) begin
                    timer_d = '0;
                end else if (timer_q != TIMER_MAX) begin
                    timer_d = timer_q + TW'(1);
                end
                if (start_replay) begin
                    timer_d = '0;
                    if (replay_num_base == 2'd3) begin
                        state_d       = RETRAIN;
                        retrain_req_d = 1'b1;
                    end else begin
                        replay_num_d = replay_num_base + 2'd1;
                        rd_ptr_d     = rd_base_d;
                        remaining_d  = count_after;
                        state_d      = REPLAY;
                    end
                end
            end
            REPLAY: begin
                if (tx_ready) begin
                    rd_ptr_d    = rd_ptr_q + AW'(1);
                    remaining_d = remaining_q - (AW+1)'(1);
                    if (remaining_q == (AW+1)'(1)) begin
                        state_d = NORMAL;
                        timer_d = '0;
                    end
                end
            end
            RETRAIN: begin
                if (retrain_done) begin
                    retrain_req_d = 1'b0;
                    replay_num_d  = 2'd0;
                    timer_d       = '0;
                    if (count_q != '0) begin
                        rd_ptr_d    = rd_base_q;
                        remaining_d = count_q;
                        state_d     = REPLAY;
                    end else begin
                        state_d = NORMAL;
                    end
                end
            end
            default: begin
                state_d = NORMAL;
            end
        endcase
    end

    // State register with asynchronous active-low reset; reset aborts any replay at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= NORMAL;
            wr_ptr_q       <= '0;
            rd_base_q      <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            remaining_q    <= '0;
            next_seq_q     <= '0;
            acked_seq_q    <= '1;
            replay_num_q   <= '0;
            timer_q        <= '0;
            replay_valid_q <= 1'b0;
            dllp_err_q     <= 1'b0;
            retrain_req_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_base_q      <= rd_base_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            remaining_q    <= remaining_d;
            next_seq_q     <= next_seq_d;
            acked_seq_q    <= acked_seq_d;
            replay_num_q   <= replay_num_d;
            timer_q        <= timer_d;
            replay_valid_q <= replay_valid_d;
            dllp_err_q     <= dllp_err_d;
            retrain_req_q  <= retrain_req_d;
        end
    end

endmodule

// File: tb/tb_replay_ctrl.sv
// tb/tb_replay_ctrl.sv - self-checking bench for replay_ctrl: vector table, directed corners, randomized model comparison
module tb_replay_ctrl;
    localparam int AW      = 3;
    localparam int SEQ_W   = 12;
    localparam int TIMEOUT = 64;
    localparam int DEPTH   = 1 << AW;
    localparam int SEQ_MOD = 1 << SEQ_W;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             tlp_valid = 1'b0;
    logic             tlp_ready;
    logic [SEQ_W-1:0] tx_seq;
    logic             buf_we;
    logic [AW-1:0]    buf_waddr;
    logic             buf_re;
    logic [AW-1:0]    buf_raddr;
    logic             replay_valid;
    logic             tx_ready = 1'b0;
    logic             dllp_valid = 1'b0;
    logic             dllp_ready;
    logic             dllp_nak = 1'b0;
    logic [SEQ_W-1:0] dllp_seq = '0;
    logic             dllp_err;
    logic             replay_active;
    logic             retrain_req;
    logic             retrain_done = 1'b0;
    logic [AW:0]      count;
    logic             full;
    logic             empty;

    replay_ctrl #(.AW(AW), .SEQ_W(SEQ_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .tlp_valid(tlp_valid), .tlp_ready(tlp_ready), .tx_seq(tx_seq),
        .buf_we(buf_we), .buf_waddr(buf_waddr),
        .buf_re(buf_re), .buf_raddr(buf_raddr), .replay_valid(replay_valid),
        .tx_ready(tx_ready),
        .dllp_valid(dllp_valid), .dllp_ready(dllp_ready), .dllp_nak(dllp_nak),
        .dllp_seq(dllp_seq), .dllp_err(dllp_err),
        .replay_active(replay_active), .retrain_req(retrain_req), .retrain_done(retrain_done),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Behavioural reference: outstanding TLPs as a queue of sequence numbers,
    // buffer slot = seq mod DEPTH, pending replay as a queue of sequence numbers.
    typedef enum {M_NORMAL, M_REPLAY, M_RETRAIN} mmode_t;
    mmode_t m_mode;
    int     m_q[$];
    int     m_pend[$];
    int     m_next, m_acked, m_timer, m_rn;
    int     m_prev_re, m_prev_err;

    int s_tr, s_we, s_wa, s_ts, s_dr, s_re, s_ra, s_rv, s_err, s_act, s_rreq, s_cnt, s_full, s_empty;

    typedef struct {
        int rst, tv, dv, nak, sq;
        int e_tr, e_we, e_waddr, e_txseq, e_count, e_err;
    } vec_t;
    vec_t vt[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic m_reset();
        m_mode = M_NORMAL;
        m_q.delete();
        m_pend.delete();
        m_next = 0;
        m_acked = SEQ_MOD - 1;
        m_timer = 0;
        m_rn = 0;
        m_prev_re = 0;
        m_prev_err = 0;
    endtask

    task automatic sample();
        s_tr = tlp_ready;  s_we = buf_we;     s_wa = buf_waddr;   s_ts = tx_seq;
        s_dr = dllp_ready; s_re = buf_re;     s_ra = buf_raddr;   s_rv = replay_valid;
        s_err = dllp_err;  s_act = replay_active; s_rreq = retrain_req;
        s_cnt = count;     s_full = full;     s_empty = empty;
    endtask

    task automatic model_step(input int tv, input int dv, input int nak, input int sq,
                              input int txr, input int rd);
        int sz, acc, cons, e_re, err, start_rep, progress, timed_out, d;
        sz = m_q.size();
        acc = (tv != 0) && (m_mode == M_NORMAL) && (sz < DEPTH);
        cons = (dv != 0) && (m_mode == M_NORMAL);
        e_re = (m_mode == M_REPLAY) && (txr != 0);

        check("tlp_ready", s_tr, (m_mode == M_NORMAL) && (sz < DEPTH));
        check("buf_we", s_we, acc);
        if (acc != 0) begin
            check("buf_waddr", s_wa, m_next % DEPTH);
            check("tx_seq", s_ts, m_next);
        end
        check("dllp_ready", s_dr, m_mode == M_NORMAL);
        check("buf_re", s_re, e_re);
        if (e_re != 0 && m_pend.size() > 0) check("buf_raddr", s_ra, m_pend[0] % DEPTH);
        check("replay_valid", s_rv, m_prev_re);
        check("dllp_err", s_err, m_prev_err);
        check("replay_active", s_act, m_mode == M_REPLAY);
        check("retrain_req", s_rreq, m_mode == M_RETRAIN);
        check("count", s_cnt, sz);
        check("full", s_full, sz == DEPTH);
        check("empty", s_empty, sz == 0);

        err = 0; start_rep = 0; progress = 0;
        timed_out = (cons == 0) && (sz > 0) && (m_timer >= TIMEOUT - 1);
        case (m_mode)
            M_NORMAL: begin
                if (cons != 0) begin
                    d = (sq - m_acked + SEQ_MOD) % SEQ_MOD;
                    if (d > sz) err = 1;
                    else begin
                        for (int k = 0; k < d; k++) void'(m_q.pop_front());
                        m_acked = sq;
                        if (d > 0) begin m_timer = 0; m_rn = 0; progress = 1; end
                        if (nak != 0) start_rep = 1;
                    end
                end
                if (acc != 0) begin
                    m_q.push_back(m_next);
                    m_next = (m_next + 1) % SEQ_MOD;
                end
                if (progress == 0) m_timer = (sz > 0) ? m_timer + 1 : 0;
                if (m_q.size() == 0) start_rep = 0;
                if (timed_out != 0) start_rep = 1;
                if (start_rep != 0) begin
                    m_timer = 0;
                    if (m_rn == 3) m_mode = M_RETRAIN;
                    else begin
                        m_rn++;
                        m_pend = m_q;
                        m_mode = M_REPLAY;
                    end
                end
            end
            M_REPLAY: begin
                if (txr != 0) begin
                    void'(m_pend.pop_front());
                    if (m_pend.size() == 0) begin m_mode = M_NORMAL; m_timer = 0; end
                end
            end
            default: begin
                if (rd != 0) begin
                    m_rn = 0;
                    m_timer = 0;
                    if (sz > 0) begin m_pend = m_q; m_mode = M_REPLAY; end
                    else m_mode = M_NORMAL;
                end
            end
        endcase
        m_prev_re = e_re;
        m_prev_err = err;
    endtask

    task automatic step(input int tv, input int dv, input int nak, input int sq,
                        input int txr, input int rd);
        tlp_valid = (tv != 0);
        dllp_valid = (dv != 0);
        dllp_nak = (nak != 0);
        dllp_seq = SEQ_W'(sq);
        tx_ready = (txr != 0);
        retrain_done = (rd != 0);
        @(negedge clk);
        sample();
        model_step(tv, dv, nak, sq, txr, rd);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        tlp_valid = 0; dllp_valid = 0; dllp_nak = 0; dllp_seq = '0;
        tx_ready = 0; retrain_done = 0;
        reset = 0;
        m_reset();
        @(negedge clk);
        sample();
        check("rst_count", s_cnt, 0);
        check("rst_empty", s_empty, 1);
        check("rst_full", s_full, 0);
        check("rst_retrain_req", s_rreq, 0);
        check("rst_replay_active", s_act, 0);
        check("rst_dllp_err", s_err, 0);
        check("rst_replay_valid", s_rv, 0);
        check("rst_acked_seq", int'(dut.acked_seq_q), SEQ_MOD - 1);
        @(posedge clk);
        @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table();
        vt.delete();
        // Three writes then ACK seq 1 purges two.
        vt.push_back('{1, 1, 0, 0, 0,    1, 1, 0, 0, 0, 0});
        vt.push_back('{0, 1, 0, 0, 0,    1, 1, 1, 1, 1, 0});
        vt.push_back('{0, 1, 0, 0, 0,    1, 1, 2, 2, 2, 0});
        vt.push_back('{0, 0, 1, 0, 1,    1, 0, 0, 0, 3, 0});
        vt.push_back('{0, 0, 0, 0, 0,    1, 0, 0, 0, 1, 0});
        // Fill to full, ACK everything, ninth write wraps to slot 0 with seq 8.
        vt.push_back('{1, 1, 0, 0, 0,    1, 1, 0, 0, 0, 0});
        for (int i = 1; i < 8; i++) vt.push_back('{0, 1, 0, 0, 0, 1, 1, i, i, i, 0});
        vt.push_back('{0, 1, 0, 0, 0,    0, 0, 0, 0, 8, 0});
        vt.push_back('{0, 0, 1, 0, 7,    0, 0, 0, 0, 8, 0});
        vt.push_back('{0, 1, 0, 0, 0,    1, 1, 0, 8, 0, 0});
        vt.push_back('{0, 0, 0, 0, 0,    1, 0, 0, 0, 1, 0});
        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst != 0) do_reset();
            step(vt[i].tv, vt[i].dv, vt[i].nak, vt[i].sq, 1, 0);
            check($sformatf("vec%0d.tlp_ready", i), s_tr, vt[i].e_tr);
            check($sformatf("vec%0d.buf_we", i), s_we, vt[i].e_we);
            if (vt[i].e_we != 0) begin
                check($sformatf("vec%0d.buf_waddr", i), s_wa, vt[i].e_waddr);
                check($sformatf("vec%0d.tx_seq", i), s_ts, vt[i].e_txseq);
            end
            check($sformatf("vec%0d.count", i), s_cnt, vt[i].e_count);
            check($sformatf("vec%0d.dllp_err", i), s_err, vt[i].e_err);
            if (i == 4) check("vec4.rd_base", int'(dut.rd_base_q), 2);
        end
    endtask

    task automatic seq_nak();
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, 0);
        step(0, 1, 1, 0, 1, 0);
        check("nak.replay_num", int'(dut.replay_num_q), 1);
        step(0, 0, 0, 0, 1, 0);
        check("nak.re0", s_re, 1); check("nak.raddr0", s_ra, 1); check("nak.count", s_cnt, 3);
        step(0, 0, 0, 0, 0, 0);
        check("nak.stall1", s_re, 0);
        step(0, 0, 0, 0, 0, 0);
        check("nak.stall2", s_re, 0);
        step(0, 0, 0, 0, 1, 0);
        check("nak.re1", s_re, 1); check("nak.raddr1", s_ra, 2);
        step(0, 0, 0, 0, 1, 0);
        check("nak.re2", s_re, 1); check("nak.raddr2", s_ra, 3);
        step(0, 0, 0, 0, 1, 0);
        check("nak.done_active", s_act, 0); check("nak.done_re", s_re, 0);
    endtask

    task automatic seq_timeout();
        int wstep, found, n_rep, prev;
        do_reset();
        wstep = cyc;
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            step(0, 0, 0, 0, 1, 0);
            if (s_act != 0) begin
                found = 1;
                check("timeout.start_edge_after_write", cyc - 2 - wstep, TIMEOUT);
            end
        end
        check("timeout.replay_seen", found, 1);
        n_rep = 1; prev = 1; found = 0;
        for (int k = 0; k < 1000 && found == 0; k++) begin
            step(0, 0, 0, 0, 1, 0);
            if (s_act != 0 && prev == 0) n_rep++;
            prev = s_act;
            if (s_rreq != 0) found = 1;
        end
        check("timeout.retrain_seen", found, 1);
        check("timeout.replays_before_retrain", n_rep, 3);
        check("timeout.replay_num_at_retrain", int'(dut.replay_num_q), 3);
        step(0, 0, 0, 0, 1, 0);
        check("retrain.held", s_rreq, 1);
        step(0, 0, 0, 0, 1, 1);
        check("retrain.replay_num_cleared", int'(dut.replay_num_q), 0);
        step(0, 0, 0, 0, 1, 0);
        check("retrain.req_cleared", s_rreq, 0); check("retrain.active", s_act, 1);
        check("retrain.re0", s_re, 1); check("retrain.raddr0", s_ra, 0);
        step(0, 0, 0, 0, 1, 0);
        check("retrain.re1", s_re, 1); check("retrain.raddr1", s_ra, 1);
        step(0, 0, 0, 0, 1, 0);
        check("retrain.done_active", s_act, 0);
    endtask

    task automatic seq_wrap();
        do_reset();
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        step(0, 1, 0, 100, 1, 0);
        step(0, 1, 0, 1, 1, 0);
        check("window.err_pulse", s_err, 1); check("window.count_kept", s_cnt, 2);
        step(0, 0, 0, 0, 1, 0);
        check("window.err_one_cycle", s_err, 0); check("window.count_after_ack", s_cnt, 0);
        for (int i = 2; i < SEQ_MOD; i++) step(1, 1, 0, i - 1, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        check("wrap.buf_we", s_we, 1); check("wrap.tx_seq", s_ts, 0); check("wrap.buf_waddr", s_wa, 0);
        step(0, 1, 0, 0, 1, 0);
        check("wrap.count_before_ack", s_cnt, 2);
        step(0, 0, 0, 0, 1, 0);
        check("wrap.empty", s_empty, 1); check("wrap.no_err", s_err, 0);
    endtask

    task automatic seq_reset_mid_replay();
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 0);
        step(0, 1, 1, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        check("abort.in_replay", s_act, 1);
        tlp_valid = 0; dllp_valid = 0; tx_ready = 1; retrain_done = 0;
        reset = 0;
        #1;
        check("abort.buf_re", buf_re, 0);
        check("abort.replay_active", replay_active, 0);
        check("abort.count", count, 0);
        check("abort.empty", empty, 1);
        m_reset();
        @(negedge clk);
        check("abort.buf_re_held", buf_re, 0);
        reset = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic random_phase(input int n, input int dv_pct);
        int tv, dv, nak, sq, txr, rd;
        do_reset();
        for (int i = 0; i < n; i++) begin
            tv  = int'($urandom_range(0, 1));
            dv  = (int'($urandom_range(0, 99)) < dv_pct) ? 1 : 0;
            nak = ($urandom_range(0, 3) == 0) ? 1 : 0;
            if ($urandom_range(0, 9) == 0) sq = int'($urandom_range(0, SEQ_MOD - 1));
            else sq = (m_acked + int'($urandom_range(0, m_q.size()))) % SEQ_MOD;
            txr = ($urandom_range(0, 3) != 0) ? 1 : 0;
            rd  = ($urandom_range(0, 7) == 0) ? 1 : 0;
            step(tv, dv, nak, sq, txr, rd);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        run_table();
        seq_nak();
        seq_timeout();
        seq_wrap();
        seq_reset_mid_replay();
        random_phase(3000, 20);
        random_phase(3000, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
